alu32_op_sequencer: RTL and testbench



---
 rtl/alu32_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu32_op_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_op_sequencer.sv
// Issue/sequencing stage in front of the 32-bit ALU: one ALU pass for native ops,
// two chained passes for ADD64 and SUB32. Optional macro ALU_SEQ_PIPE_EN enables zero-bubble issue from DONE.
module alu32_op_sequencer #(
    parameter logic [63:0] ILLEGAL_RES = 64'h0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [3:0]  REQ_OP,
    input  logic [63:0] REQ_OPA,
    input  logic [63:0] REQ_OPB,
    input  logic        REQ_CI,
    output logic [31:0] ALU_IN1,
    output logic [31:0] ALU_IN2,
    output logic        ALU_CI,
    output logic [2:0]  ALU_A,
    input  logic [31:0] ALU_OUT,
    input  logic        ALU_CO,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [63:0] RSP_RES,
    output logic        RSP_CO,
    output logic        RSP_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_ADD64 = 4'd8;
    localparam logic [3:0] OP_SUB32 = 4'd9;
    localparam logic [2:0] A_NOT    = 3'd3;
    localparam logic [2:0] A_ADD    = 3'd4;
    localparam logic [2:0] A_IDLE   = 3'd7;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [63:0] opa_q, opa_d;
    logic [63:0] opb_q, opb_d;
    logic        ci_q, ci_d;
    logic        carry_q, carry_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic        rsp_co_q, rsp_co_d;
    logic        rsp_err_q, rsp_err_d;
    logic        accept;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            op_q      <= 4'd0;
            opa_q     <= 64'd0;
            opb_q     <= 64'd0;
            ci_q      <= 1'b0;
            carry_q   <= 1'b0;
            res_lo_q  <= 32'd0;
            res_hi_q  <= 32'd0;
            rsp_co_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            ci_q      <= ci_d;
            carry_q   <= carry_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            rsp_co_q  <= rsp_co_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        ci_d      = ci_q;
        carry_d   = carry_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        rsp_co_d  = rsp_co_q;
        rsp_err_d = rsp_err_q;
        REQ_READY = 1'b0;
        ALU_A     = A_IDLE;
        ALU_IN1   = 32'd0;
        ALU_IN2   = 32'd0;
        ALU_CI    = 1'b0;

        case (state_q)
            IDLE: begin
                REQ_READY = 1'b1;
            end
            PASS1: begin
                if (op_q == OP_SUB32) begin
                    // a - b computed as a + ~b + 1; this pass forms ~b
                    ALU_A   = A_NOT;
                    ALU_IN1 = opb_q[31:0];
                end else begin
                    ALU_A   = op_q[3] ? A_ADD : op_q[2:0];
                    ALU_IN1 = opa_q[31:0];
                    ALU_IN2 = opb_q[31:0];
                    ALU_CI  = (op_q == OP_ADD || op_q == OP_ADD64) ? ci_q : 1'b0;
                end
                res_lo_d = ALU_OUT;
                carry_d  = ALU_CO;
                if (op_q[3]) begin
                    state_d = PASS2;
                end else begin
                    state_d  = DONE;
                    rsp_co_d = (op_q == OP_ADD) ? ALU_CO : 1'b0;
                end
            end
            PASS2: begin
                ALU_A = A_ADD;
                if (op_q == OP_ADD64) begin
                    ALU_IN1  = opa_q[63:32];
                    ALU_IN2  = opb_q[63:32];
                    ALU_CI   = carry_q;
                    res_hi_d = ALU_OUT;
                end else begin
                    ALU_IN1  = opa_q[31:0];
                    ALU_IN2  = res_lo_q;
                    ALU_CI   = 1'b1;
                    res_lo_d = ALU_OUT;
                end
                rsp_co_d = ALU_CO;
                state_d  = DONE;
            end
            DONE: begin
                if (RSP_READY) begin
                    state_d = IDLE;
                end
`ifdef ALU_SEQ_PIPE_EN
                REQ_READY = RSP_READY;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides the DONE->IDLE transition so a pipelined issue goes straight on.
        accept = REQ_VALID & REQ_READY;
        if (accept) begin
            op_d      = REQ_OP;
            opa_d     = REQ_OPA;
            opb_d     = REQ_OPB;
            ci_d      = REQ_CI;
            carry_d   = 1'b0;
            rsp_co_d  = 1'b0;
            if (REQ_OP > OP_SUB32) begin
                state_d   = DONE;
                rsp_err_d = 1'b1;
                res_hi_d  = ILLEGAL_RES[63:32];
                res_lo_d  = ILLEGAL_RES[31:0];
            end else begin
                state_d   = PASS1;
                rsp_err_d = 1'b0;
                res_hi_d  = 32'd0;
                res_lo_d  = 32'd0;
            end
        end
    end

    assign RSP_VALID = (state_q == DONE);
    assign RSP_RES   = {res_hi_q, res_lo_q};
    assign RSP_CO    = rsp_co_q;
    assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Directed bench for alu32_op_sequencer with a behavioural ALU on the ALU_* ports.
module tb_alu32_op_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [3:0]  REQ_OP;
    logic [63:0] REQ_OPA;
    logic [63:0] REQ_OPB;
    logic        REQ_CI;
    logic [31:0] ALU_IN1;
    logic [31:0] ALU_IN2;
    logic        ALU_CI;
    logic [2:0]  ALU_A;
    logic [31:0] ALU_OUT;
    logic        ALU_CO;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [63:0] RSP_RES;
    logic        RSP_CO;
    logic        RSP_ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu32_op_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CI(REQ_CI),
        .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .ALU_CI(ALU_CI), .ALU_A(ALU_A),
        .ALU_OUT(ALU_OUT), .ALU_CO(ALU_CO),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RES(RSP_RES),
        .RSP_CO(RSP_CO), .RSP_ERR(RSP_ERR)
    );

    // Behavioural stand-in for the gate-level ALU: 0 AND, 1 OR, 2 XOR, 3 NOT In1, 4 ADD.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, ALU_IN1} + {1'b0, ALU_IN2} + {32'd0, ALU_CI};
        ALU_OUT = 32'd0;
        ALU_CO  = 1'b0;
        case (ALU_A)
            3'd0: ALU_OUT = ALU_IN1 & ALU_IN2;
            3'd1: ALU_OUT = ALU_IN1 | ALU_IN2;
            3'd2: ALU_OUT = ALU_IN1 ^ ALU_IN2;
            3'd3: ALU_OUT = ~ALU_IN1;
            3'd4: begin
                ALU_OUT = alu_sum[31:0];
                ALU_CO  = alu_sum[32];
            end
            default: ALU_OUT = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] opa;
        logic [63:0] opb;
        logic        ci;
        logic [63:0] res;
        logic        co;
        logic        err;
        int          lat;
        logic [2:0]  a1;
        logic        ci1;
    } vec_t;

    vec_t vecs [16];

    task automatic wait_ready();
        int n = 0;
        while (REQ_READY !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (REQ_READY !== 1'b1) chk("ready_timeout", {63'd0, REQ_READY}, 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        logic [2:0] a1;
        logic ci1;
        wait_ready();
        REQ_OP = v.op; REQ_OPA = v.opa; REQ_OPB = v.opb; REQ_CI = v.ci;
        REQ_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        a1 = ALU_A;
        ci1 = ALU_CI;
        lat = 1;
        while (RSP_VALID !== 1'b1 && lat < 10) begin
            @(negedge CLK);
            lat++;
        end
        chk($sformatf("v%0d_res", idx), RSP_RES, v.res);
        chk($sformatf("v%0d_co", idx), {63'd0, RSP_CO}, {63'd0, v.co});
        chk($sformatf("v%0d_err", idx), {63'd0, RSP_ERR}, {63'd0, v.err});
        chk($sformatf("v%0d_lat", idx), 64'(lat), 64'(v.lat));
        chk($sformatf("v%0d_alu_a1", idx), {61'd0, a1}, {61'd0, v.a1});
        chk($sformatf("v%0d_alu_ci1", idx), {63'd0, ci1}, {63'd0, v.ci1});
        @(negedge CLK);
    endtask

    initial begin
        //           op     opa                     opb                     ci    res                     co    err  lat a1    ci1
        vecs[0]  = '{4'd0,  64'hF0F0F0F0,           64'h0FF0FF00,           1'b1, 64'h00F0F000,           1'b0, 1'b0, 2, 3'd0, 1'b0};
        vecs[1]  = '{4'd1,  64'h12340000,           64'h00005678,           1'b0, 64'h12345678,           1'b0, 1'b0, 2, 3'd1, 1'b0};
        vecs[2]  = '{4'd2,  64'hFFFF0000,           64'h0F0F0F0F,           1'b1, 64'hF0F00F0F,           1'b0, 1'b0, 2, 3'd2, 1'b0};
        vecs[3]  = '{4'd3,  64'h0000FFFF,           64'h12345678,           1'b0, 64'hFFFF0000,           1'b0, 1'b0, 2, 3'd3, 1'b0};
        vecs[4]  = '{4'd4,  64'hFFFFFFFF,           64'h0,                  1'b1, 64'h0,                  1'b1, 1'b0, 2, 3'd4, 1'b1};
        vecs[5]  = '{4'd4,  64'h1,                  64'h2,                  1'b0, 64'h3,                  1'b0, 1'b0, 2, 3'd4, 1'b0};
        vecs[6]  = '{4'd4,  64'hDEAD0000_00000010,  64'h20,                 1'b0, 64'h30,                 1'b0, 1'b0, 2, 3'd4, 1'b0};
        vecs[7]  = '{4'd8,  64'h00000000_FFFFFFFF,  64'h1,                  1'b0, 64'h00000001_00000000,  1'b0, 1'b0, 3, 3'd4, 1'b0};
        vecs[8]  = '{4'd8,  64'hFFFFFFFF_FFFFFFFF,  64'hFFFFFFFF_FFFFFFFF,  1'b0, 64'hFFFFFFFF_FFFFFFFE,  1'b1, 1'b0, 3, 3'd4, 1'b0};
        vecs[9]  = '{4'd8,  64'h00000001_00000000,  64'h00000002_FFFFFFFF,  1'b1, 64'h00000004_00000000,  1'b0, 1'b0, 3, 3'd4, 1'b1};
        vecs[10] = '{4'd9,  64'h5,                  64'h7,                  1'b0, 64'hFFFFFFFE,           1'b0, 1'b0, 3, 3'd3, 1'b0};
        vecs[11] = '{4'd9,  64'h7,                  64'h5,                  1'b0, 64'h2,                  1'b1, 1'b0, 3, 3'd3, 1'b0};
        vecs[12] = '{4'd9,  64'hFFFF0000_00000009,  64'h9,                  1'b1, 64'h0,                  1'b1, 1'b0, 3, 3'd3, 1'b0};
        vecs[13] = '{4'hC,  64'h1234,               64'h5678,               1'b0, 64'h0,                  1'b0, 1'b1, 1, 3'd7, 1'b0};
        vecs[14] = '{4'hF,  64'hFFFFFFFF,           64'hFFFFFFFF,           1'b1, 64'h0,                  1'b0, 1'b1, 1, 3'd7, 1'b0};
        vecs[15] = '{4'hA,  64'h1,                  64'h1,                  1'b0, 64'h0,                  1'b0, 1'b1, 1, 3'd7, 1'b0};

        RST_N = 1'b0; REQ_VALID = 1'b0; REQ_OP = 4'd0; REQ_OPA = 64'd0; REQ_OPB = 64'd0;
        REQ_CI = 1'b0; RSP_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_rsp_valid", {63'd0, RSP_VALID}, 64'd0);
        chk("rst_rsp_res", RSP_RES, 64'd0);
        chk("rst_alu_a", {61'd0, ALU_A}, 64'd7);
        chk("rst_req_ready", {63'd0, REQ_READY}, 64'd1);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // SUB32 7-5 under backpressure, with a competing request held on REQ_VALID.
        wait_ready();
        RSP_READY = 1'b0;
        REQ_OP = 4'd9; REQ_OPA = 64'h7; REQ_OPB = 64'h5; REQ_CI = 1'b0; REQ_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_OP = 4'd1; REQ_OPA = 64'hAAAA; REQ_OPB = 64'h5555;
        chk("sub_p1_a", {61'd0, ALU_A}, 64'd3);
        chk("sub_p1_in1", {32'd0, ALU_IN1}, 64'h5);
        chk("sub_p1_req_ready", {63'd0, REQ_READY}, 64'd0);
        @(negedge CLK);
        chk("sub_p2_a", {61'd0, ALU_A}, 64'd4);
        chk("sub_p2_in2", {32'd0, ALU_IN2}, 64'hFFFFFFFA);
        chk("sub_p2_ci", {63'd0, ALU_CI}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk($sformatf("bp%0d_valid", c), {63'd0, RSP_VALID}, 64'd1);
            chk($sformatf("bp%0d_res", c), RSP_RES, 64'h2);
            chk($sformatf("bp%0d_co", c), {63'd0, RSP_CO}, 64'd1);
            chk($sformatf("bp%0d_req_ready", c), {63'd0, REQ_READY}, 64'd0);
            chk($sformatf("bp%0d_alu_a", c), {61'd0, ALU_A}, 64'd7);
        end
        REQ_VALID = 1'b0;
        RSP_READY = 1'b1;
        @(negedge CLK);
        chk("bp_release_valid", {63'd0, RSP_VALID}, 64'd0);
        chk("bp_release_ready", {63'd0, REQ_READY}, 64'd1);

        // Reset while ADD64 is in its second pass.
        REQ_OP = 4'd8; REQ_OPA = {64{1'b1}}; REQ_OPB = {64{1'b1}}; REQ_CI = 1'b0; REQ_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("rst2_in_pass2_a", {61'd0, ALU_A}, 64'd4);
        chk("rst2_in_pass2_in1", {32'd0, ALU_IN1}, 64'hFFFFFFFF);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rst2_valid", {63'd0, RSP_VALID}, 64'd0);
        chk("rst2_res", RSP_RES, 64'd0);
        chk("rst2_req_ready", {63'd0, REQ_READY}, 64'd1);
        chk("rst2_alu_a", {61'd0, ALU_A}, 64'd7);
        RST_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk($sformatf("rst2_no_rsp%0d", c), {63'd0, RSP_VALID}, 64'd0);
        end

        // Back-to-back AND then OR.
        REQ_OP = 4'd0; REQ_OPA = 64'hFF00FF00; REQ_OPB = 64'h0F0F0F0F; REQ_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b_first_valid", {63'd0, RSP_VALID}, 64'd1);
        chk("b2b_first_res", RSP_RES, 64'h0F000F00);
        REQ_OP = 4'd1; REQ_OPA = 64'h0F; REQ_OPB = 64'hF0; REQ_VALID = 1'b1;
`ifdef ALU_SEQ_PIPE_EN
        chk("b2b_ready_in_done", {63'd0, REQ_READY}, 64'd1);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("b2b_pass1_valid", {63'd0, RSP_VALID}, 64'd0);
        chk("b2b_pass1_a", {61'd0, ALU_A}, 64'd1);
        @(negedge CLK);
`else
        chk("b2b_ready_in_done", {63'd0, REQ_READY}, 64'd0);
        @(negedge CLK);
        chk("b2b_idle_valid", {63'd0, RSP_VALID}, 64'd0);
        chk("b2b_idle_ready", {63'd0, REQ_READY}, 64'd1);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        chk("b2b_pass1_a", {61'd0, ALU_A}, 64'd1);
        @(negedge CLK);
`endif
        chk("b2b_second_valid", {63'd0, RSP_VALID}, 64'd1);
        chk("b2b_second_res", RSP_RES, 64'hFF);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
